// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle for counter_seq_ctrl: sequence commands in, count and status out.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int RC_W  = 8
);
  logic             start;
  logic             abort;
  logic             pause;
  logic             dir;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;
  logic             done;
  logic [RC_W-1:0]  reload_cnt;

  modport master (output start, abort, pause, dir, load_val,
                  input  q, busy, tc, done, reload_cnt);
  modport slave  (input  start, abort, pause, dir, load_val,
                  output q, busy, tc, done, reload_cnt);
endinterface

// File: rtl/counter_seq_ctrl.sv
// Loadable up/down sequence counter with pause/abort and a registered terminal-count pulse.
// COUNTER_SEQ_AUTO_RELOAD_EN: reload load_val at terminal and count reloads instead of stopping in DONE.
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int RC_W  = 8
) (
  input  logic               clk,
  input  logic               r,
  counter_seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_r, q_nxt, load_l, load_nxt;
  logic             dir_l, dir_nxt;
  logic             tc_r, tc_nxt;
  logic             armed;
  logic             at_term;
  logic [RC_W-1:0]  rc_r;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
  logic [RC_W-1:0]  rc_nxt;
`endif

  assign at_term = dir_l ? (q_r == '1) : (q_r == '0);

  // The first edge after r rises only arms the block; inputs are sampled from the next edge on.
  always_ff @(posedge clk or negedge r) begin
    if (!r) armed <= 1'b0;
    else    armed <= 1'b1;
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state  <= IDLE;
      q_r    <= '0;
      load_l <= '0;
      dir_l  <= 1'b0;
      tc_r   <= 1'b0;
    end else if (armed) begin
      state  <= state_nxt;
      q_r    <= q_nxt;
      load_l <= load_nxt;
      dir_l  <= dir_nxt;
      tc_r   <= tc_nxt;
    end
  end

`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge r) begin
    if (!r)         rc_r <= '0;
    else if (armed) rc_r <= rc_nxt;
  end
`else
  assign rc_r = '0;
`endif

  always_comb begin
    state_nxt = state;
    q_nxt     = q_r;
    load_nxt  = load_l;
    dir_nxt   = dir_l;
    tc_nxt    = 1'b0;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
    rc_nxt    = rc_r;
`endif
    if (bus.abort) begin
      state_nxt = IDLE;
      q_nxt     = '0;
    end else begin
      unique case (state)
        IDLE, DONE: if (bus.start) begin
          state_nxt = LOAD;
          dir_nxt   = bus.dir;
          load_nxt  = bus.load_val;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
          rc_nxt    = '0;
`endif
        end
        LOAD: begin
          state_nxt = RUN;
          q_nxt     = load_l;
        end
        RUN: begin
          if (bus.pause) begin
            state_nxt = PAUSE;
          end else if (at_term) begin
            tc_nxt = 1'b1;
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
            q_nxt  = load_l;
            if (rc_r != '1) rc_nxt = rc_r + RC_W'(1);
`else
            state_nxt = DONE;
`endif
          end else begin
            q_nxt = dir_l ? q_r + WIDTH'(1) : q_r - WIDTH'(1);
          end
        end
        PAUSE: if (!bus.pause) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.q          = q_r;
  assign bus.tc         = tc_r;
  assign bus.busy       = (state == LOAD) || (state == RUN) || (state == PAUSE);
  assign bus.done       = (state == DONE);
  assign bus.reload_cnt = rc_r;

endmodule

// File: doc/counter_seq_ctrl.md
COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have parameter RC_W, default 8, reload-counter width in bits.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port r  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin sequence; sampled only in IDLE or DONE.
REQ-006 SHALL have port abort  input  1  return to IDLE; highest priority after reset.
REQ-007 SHALL have port pause  input  1  level; holds count while high in RUN.
REQ-008 SHALL have port dir  input  1  1 = up, 0 = down; latched on accepted start.
REQ-009 SHALL have port load_val  input  WIDTH  start value; latched on accepted start.
REQ-010 SHALL have port q  output  WIDTH  current count, registered.
REQ-011 SHALL have port busy  output  1  high in LOAD, RUN and PAUSE.
REQ-012 SHALL have port tc  output  1  one-cycle registered terminal-count pulse.
REQ-013 SHALL have port done  output  1  high while in DONE.
REQ-014 SHALL have port reload_cnt  output  RC_W  number of auto-reloads since last accepted start.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, PAUSE and DONE.
REQ-016 SHALL move IDLE->LOAD or DONE->LOAD on the edge start=1, latch dir and load_val, and clear reload_cnt.
REQ-017 SHALL move LOAD->RUN on the next edge, with q=load_val.
REQ-018 SHALL step q in RUN by +1 (dir_l=1) or -1 (dir_l=0), modulo 2^WIDTH, on each edge with pause=0 and q not at terminal.
REQ-019 SHALL define terminal as all-ones when counting up and zero when counting down.
REQ-020 SHALL, in RUN with pause=0 and q at terminal, not step q, and assert tc for exactly the following cycle.
REQ-021 SHALL move RUN->PAUSE on an edge with pause=1, hold q, and move PAUSE->RUN on the first edge with pause=0; terminal detection is suppressed while pause=1.
REQ-022 SHALL, on abort=1 in any state, move to IDLE on that edge with q=0, tc=0 and reload_cnt held; start, pause and terminal are ignored on that edge.
REQ-023 SHALL ignore start in LOAD, RUN and PAUSE.
REQ-024 SHALL go straight from RUN to terminal handling on the first RUN edge when load_val equals terminal.
REQ-025 SHALL keep q holding its final value in DONE until the next accepted start or abort.

Reset
REQ-026 SHALL, while r=0, immediately force state IDLE, q=0, busy=0, tc=0, done=0, reload_cnt=0, dir_l=0 and load latch=0, with no clock required.
REQ-027 SHALL sample no input on the first edge after r rises unless r was synchronised high before that edge; start is accepted from the second edge after deassertion.
REQ-028 SHALL, on reset mid-operation, discard the sequence in progress; no tc is produced.

Configuration
REQ-029 SHALL use macro COUNTER_SEQ_AUTO_RELOAD_EN.
REQ-030 SHALL, with the macro defined, at terminal in RUN: load q=load_val, increment reload_cnt (saturating at all-ones), and stay in RUN.
REQ-031 SHALL, without the macro, at terminal in RUN: move to DONE with q held at terminal; reload_cnt stays 0 and reload_cnt is tied to 0.

Verification
REQ-032 SHALL cover reset: r=0 mid-RUN -> q=0, busy=0, done=0, tc=0 before the next clk edge; start is accepted after release.
REQ-033 SHALL cover down run without the macro: start, dir=0, load_val=5 -> q=5,4,3,2,1,0 on consecutive edges; next edge: tc=1 for one cycle, done=1, busy=0, q=0.
REQ-034 SHALL cover up run with pause: dir=1, load_val=12, pause high 3 cycles while q=13 -> q holds 13 for 3 cycles, then 14,15; tc after 15, with no tc while paused at any value.
REQ-035 SHALL cover abort: abort=1 in RUN with q=9 -> next edge IDLE, q=0, busy=0, tc=0; start in the same cycle is ignored.
REQ-036 SHALL cover auto-reload with the macro: dir=1, load_val=14 -> q=14,15, then tc and q=14, with reload_cnt incrementing 1,2,3 on each tc; RC_W=2 saturates at 3.
REQ-037 SHALL cover edge cases: start while in RUN leaves q/dir unchanged; load_val=0 with dir=0 gives tc on the first RUN edge, then DONE.
